mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 The module SHALL have parameter MEM_WAIT_MAX, default 15: data-memory wait cycles before timeout (legal range 1..15).
REQ-002 The module SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 The module SHALL have port instr, input, 32: fetched instruction word; sampled only when instr_valid=1 in FETCH.
REQ-005 The module SHALL have port instr_valid, input, 1: instruction memory returns instr.
REQ-006 The module SHALL have port mem_ready, input, 1: data memory completes the current lw/sw access.
REQ-007 The module SHALL have port alu_zero, input, 1: ALU result is zero, used for beq.
REQ-008 The module SHALL have port fetch_req, output, 1: request an instruction fetch.
REQ-009 The module SHALL have port ir_load, output, 1: load the instruction register.
REQ-010 The module SHALL have ports alu_opcode and alu_funct, output, 6 each: registered opcode and funct that drive the ALU.
REQ-011 The module SHALL have port alu_src_imm, output, 1: ALU in2 = sign-extended imm (lw/sw).
REQ-012 The module SHALL have ports mem_rd and mem_wr, output, 1 each: data-memory read and write strobes.
REQ-013 The module SHALL have ports reg_we and wb_sel, output, 1 each: register write enable; wb_sel=1 selects memory data, 0 selects ALU result.
REQ-014 The module SHALL have ports pc_we and pc_branch, output, 1 each: PC update; pc_branch=1 selects the branch target, 0 selects PC+4.
REQ-015 The module SHALL have ports illegal and timeout, output, 1 each: sticky error flags.
REQ-016 The module SHALL have port retired, output, 16: count of retired legal instructions.
REQ-017 The module SHALL have port state, output, 3: current FSM state.

Function
REQ-018 FSM states SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-019 Legal instructions SHALL be R-type (opcode 000000) with funct 100000 (add), 100010 (sub), 100100 (and) or 100101 (or), plus lw (100011), sw (101011) and beq (000100); all other opcode/funct combinations SHALL be illegal.
REQ-020 FETCH: fetch_req=1 until instr_valid; on instr_valid, ir_load=1 in the same cycle and the next state is DECODE; instr_valid outside FETCH SHALL be ignored.
REQ-021 DECODE: alu_opcode/alu_funct SHALL be latched from instr[31:26]/instr[5:0] at the FETCH->DECODE edge.
REQ-022 DECODE, illegal instruction: pc_we=1, pc_branch=0, illegal set, next state FETCH.
REQ-023 DECODE, legal instruction: next state EXEC.
REQ-024 alu_src_imm SHALL be 1 in EXEC and MEM for lw/sw and 0 otherwise.
REQ-025 EXEC transitions SHALL be: R-type -> WB; lw/sw -> MEM; beq -> pc_we=1, pc_branch=alu_zero, retired++, next state FETCH.
REQ-026 MEM: mem_rd (lw) or mem_wr (sw) SHALL be held high, and a 4-bit wait counter SHALL be cleared on MEM entry and incremented on each cycle without mem_ready.
REQ-027 MEM, mem_ready=1: lw -> WB; sw -> pc_we=1, retired++, next state FETCH.
REQ-028 MEM, wait counter equal to MEM_WAIT_MAX without mem_ready: timeout set, pc_we=1, next state FETCH, retired unchanged.
REQ-029 When mem_ready=1 in the same cycle the counter reaches MEM_WAIT_MAX, mem_ready SHALL win and timeout SHALL NOT be set.
REQ-030 WB: reg_we=1, wb_sel=1 for lw and 0 for R-type, pc_we=1, retired++, next state FETCH.
REQ-031 All strobes (fetch_req, ir_load, mem_rd, mem_wr, reg_we, pc_we) SHALL be Moore/Mealy combinational on state and inputs as stated above, and 0 in all other cases.
REQ-032 Each instruction SHALL produce exactly one pc_we pulse.
REQ-033 Cycle counts with zero memory wait SHALL be: R-type 4, lw 5, sw 4, beq 3, illegal 2.
REQ-034 retired SHALL wrap from 0xFFFF to 0x0000.
REQ-035 illegal and timeout SHALL clear only on reset.

Reset
REQ-036 With rst_n=0 at a rising edge: state=FETCH, alu_opcode=alu_funct=0, wait counter=0, retired=0, illegal=timeout=0.
REQ-037 While rst_n=0, all strobes SHALL be 0, including fetch_req.
REQ-038 Reset asserted mid-operation (e.g. in MEM) SHALL abort the instruction with no reg_we, pc_we or retired update, and FETCH SHALL resume on the first edge after rst_n=1.

Verification
REQ-039 add (opcode 0, funct 0x20), instr_valid immediate -> states 0,1,2,4; reg_we=1 and wb_sel=0 in cycle 4; retired=1.
REQ-040 lw, mem_ready after 3 wait cycles -> mem_rd high 4 cycles, then WB with wb_sel=1, pc_we once.
REQ-041 beq with alu_zero=1 then alu_zero=0 -> pc_branch 1 then 0 in EXEC; no reg_we.
REQ-042 sw, mem_ready never asserted, MEM_WAIT_MAX=15 -> timeout=1 after 15 MEM cycles; retired unchanged; next state FETCH.
REQ-043 opcode 0x3F -> illegal=1 in DECODE, pc_we pulse, retired unchanged.
REQ-044 retired preset to 0xFFFF by 65535 retires, then one more -> retired=0x0000; rst_n=0 during MEM -> no strobes, state=0.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// ALU opcode/funct registers, data-memory timeout and retired-instruction counter.
module mips_mc_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        fetch_req,
  output logic        ir_load,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_funct,
  output logic        alu_src_imm,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        pc_we,
  output logic        pc_branch,
  output logic        illegal,
  output logic        timeout,
  output logic [15:0] retired,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Timeout fires on the cycle whose increment would bring the counter to MEM_WAIT_MAX.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

  state_t      st;
  logic [3:0]  wait_cnt;
  logic [15:0] retired_q;
  logic        illegal_q;
  logic        timeout_q;

  logic is_r, is_lw, is_sw, is_beq, legal;
  logic unused_instr_bits;

  assign unused_instr_bits = ^instr[25:6];

  always_comb begin
    is_r   = (alu_opcode == 6'b000000) &&
             ((alu_funct == 6'b100000) || (alu_funct == 6'b100010) ||
              (alu_funct == 6'b100100) || (alu_funct == 6'b100101));
    is_lw  = (alu_opcode == 6'b100011);
    is_sw  = (alu_opcode == 6'b101011);
    is_beq = (alu_opcode == 6'b000100);
    legal  = is_r || is_lw || is_sw || is_beq;
  end

  // Strobes decode the current state and inputs; everything is held low in reset.
  always_comb begin
    fetch_req   = 1'b0;
    ir_load     = 1'b0;
    alu_src_imm = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    pc_we       = 1'b0;
    pc_branch   = 1'b0;
    if (rst_n) begin
      case (st)
        S_FETCH: begin
          fetch_req = 1'b1;
          ir_load   = instr_valid;
        end
        S_DECODE: pc_we = !legal;
        S_EXEC: begin
          alu_src_imm = is_lw || is_sw;
          if (is_beq) begin
            pc_we     = 1'b1;
            pc_branch = alu_zero;
          end
        end
        S_MEM: begin
          alu_src_imm = is_lw || is_sw;
          mem_rd      = is_lw;
          mem_wr      = is_sw;
          if (mem_ready) pc_we = is_sw;
          else           pc_we = (wait_cnt == WAIT_LAST);
        end
        S_WB: begin
          reg_we = 1'b1;
          wb_sel = is_lw;
          pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= S_FETCH;
      alu_opcode <= 6'd0;
      alu_funct  <= 6'd0;
      wait_cnt   <= 4'd0;
      retired_q  <= 16'd0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (st)
        S_FETCH: begin
          if (instr_valid) begin
            alu_opcode <= instr[31:26];
            alu_funct  <= instr[5:0];
            st         <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (legal) begin
            st <= S_EXEC;
          end else begin
            illegal_q <= 1'b1;
            st        <= S_FETCH;
          end
        end
        S_EXEC: begin
          wait_cnt <= 4'd0;
          if (is_r) begin
            st <= S_WB;
          end else if (is_lw || is_sw) begin
            st <= S_MEM;
          end else begin
            retired_q <= retired_q + 16'd1;
            st        <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_lw) begin
              st <= S_WB;
            end else begin
              retired_q <= retired_q + 16'd1;
              st        <= S_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
            if (wait_cnt == WAIT_LAST) begin
              timeout_q <= 1'b1;
              st        <= S_FETCH;
            end
          end
        end
        S_WB: begin
          retired_q <= retired_q + 16'd1;
          st        <= S_FETCH;
        end
        default: st <= S_FETCH;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign retired = retired_q;
  assign state   = st;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: a table of whole-instruction vectors plus
// hand sequences for reset, fetch stall, counter wrap and reset inside MEM.
module tb_mips_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid, mem_ready, alu_zero;
  logic        fetch_req, ir_load, alu_src_imm, mem_rd, mem_wr;
  logic        reg_we, wb_sel, pc_we, pc_branch, illegal, timeout;
  logic [5:0]  alu_opcode, alu_funct;
  logic [15:0] retired;
  logic [2:0]  state;

  mips_mc_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .alu_zero(alu_zero), .fetch_req(fetch_req),
    .ir_load(ir_load), .alu_opcode(alu_opcode), .alu_funct(alu_funct),
    .alu_src_imm(alu_src_imm), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_branch(pc_branch),
    .illegal(illegal), .timeout(timeout), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    int          wait_n;
    logic        zero;
    int          cyc;
    int          rd_cyc;
    int          wr_cyc;
    int          imm_cyc;
    int          rwe_n;
    logic        wbs;
    logic        pcb;
    int          ret_inc;
    logic        ill;
    logic        tmo;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_ret = 16'd0;
  logic        exp_ill = 1'b0;
  logic        exp_tmo = 1'b0;
  vec_t        vecs[16];

  localparam int NEVER = 99;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'h4A5C3, fn};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_retired"}, retired, exp_ret);
    check({tag, "_illegal"}, illegal, exp_ill);
    check({tag, "_timeout"}, timeout, exp_tmo);
  endtask

  // Issues one instruction from FETCH and follows it until its pc_we pulse.
  task automatic run_vec(input int idx, input vec_t v);
    int   cyc, rd, wr, imm, rwe, mem_cnt;
    logic wbs, pcb, done, ld0;
    string tag;
    cyc = 0; rd = 0; wr = 0; imm = 0; rwe = 0; mem_cnt = 0;
    wbs = 1'b0; pcb = 1'b0; done = 1'b0; ld0 = 1'b0;
    tag = $sformatf("v%0d", idx);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      instr       = v.instr;
      instr_valid = (c == 0);
      alu_zero    = v.zero;
      mem_ready   = 1'b0;
      #1;
      if (mem_rd || mem_wr) begin
        mem_ready = (mem_cnt == v.wait_n);
        mem_cnt++;
      end
      #1;
      if (c == 0) ld0 = ir_load;
      cyc++;
      rd  += int'(mem_rd);
      wr  += int'(mem_wr);
      imm += int'(alu_src_imm);
      if (reg_we) begin
        rwe++;
        wbs = wb_sel;
      end
      if (pc_we) begin
        pcb  = pc_branch;
        done = 1'b1;
      end
    end
    @(negedge clk);
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    #1;
    exp_ret = exp_ret + 16'(v.ret_inc);
    exp_ill = exp_ill | v.ill;
    exp_tmo = exp_tmo | v.tmo;
    check({tag, "_done"},      done, 1);
    check({tag, "_ir_load"},   ld0, 1);
    check({tag, "_cycles"},    cyc, v.cyc);
    check({tag, "_mem_rd"},    rd, v.rd_cyc);
    check({tag, "_mem_wr"},    wr, v.wr_cyc);
    check({tag, "_src_imm"},   imm, v.imm_cyc);
    check({tag, "_reg_we"},    rwe, v.rwe_n);
    check({tag, "_wb_sel"},    wbs, v.wbs);
    check({tag, "_pc_branch"}, pcb, v.pcb);
    check({tag, "_state"},     state, 0);
    check_flags(tag);
  endtask

  initial begin
    //                instr           wait   z     cyc rd wr imm rwe wbs  pcb  ret ill  tmo
    vecs[0]  = '{mk(6'h00, 6'h20), 0,     1'b0, 4,  0, 0, 0,  1,  1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[1]  = '{mk(6'h00, 6'h22), 0,     1'b0, 4,  0, 0, 0,  1,  1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[2]  = '{mk(6'h00, 6'h24), 0,     1'b1, 4,  0, 0, 0,  1,  1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[3]  = '{mk(6'h00, 6'h25), 0,     1'b0, 4,  0, 0, 0,  1,  1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[4]  = '{mk(6'h23, 6'h2A), 0,     1'b0, 5,  1, 0, 2,  1,  1'b1, 1'b0, 1, 1'b0, 1'b0};
    vecs[5]  = '{mk(6'h23, 6'h2A), 3,     1'b0, 8,  4, 0, 5,  1,  1'b1, 1'b0, 1, 1'b0, 1'b0};
    vecs[6]  = '{mk(6'h2B, 6'h11), 0,     1'b0, 4,  0, 1, 2,  0,  1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[7]  = '{mk(6'h2B, 6'h11), 2,     1'b0, 6,  0, 3, 4,  0,  1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[8]  = '{mk(6'h04, 6'h07), 0,     1'b1, 3,  0, 0, 0,  0,  1'b0, 1'b1, 1, 1'b0, 1'b0};
    vecs[9]  = '{mk(6'h04, 6'h07), 0,     1'b0, 3,  0, 0, 0,  0,  1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[10] = '{mk(6'h3F, 6'h20), 0,     1'b0, 2,  0, 0, 0,  0,  1'b0, 1'b0, 0, 1'b1, 1'b0};
    vecs[11] = '{mk(6'h00, 6'h21), 0,     1'b0, 2,  0, 0, 0,  0,  1'b0, 1'b0, 0, 1'b1, 1'b0};
    vecs[12] = '{mk(6'h23, 6'h2A), 14,    1'b0, 19, 15, 0, 16, 1, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    vecs[13] = '{mk(6'h2B, 6'h11), NEVER, 1'b0, 18, 0, 15, 16, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[14] = '{mk(6'h00, 6'h20), 0,     1'b0, 4,  0, 0, 0,  1,  1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[15] = '{mk(6'h23, 6'h2A), NEVER, 1'b0, 18, 15, 0, 16, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1};

    // Reset: strobes low while rst_n=0 even with instr_valid high.
    rst_n = 1'b0; instr = 32'd0; instr_valid = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
    repeat (2) @(negedge clk);
    instr_valid = 1'b1;
    #1;
    check("rst_fetch_req", fetch_req, 0);
    check("rst_ir_load", ir_load, 0);
    check("rst_pc_we", pc_we, 0);
    check("rst_state", state, 0);
    check("rst_opcode", alu_opcode, 0);
    check("rst_funct", alu_funct, 0);
    check_flags("rst");
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_fetch_req", fetch_req, 1);

    // add with a two-cycle fetch stall; instr_valid held high afterwards must be ignored.
    repeat (2) begin
      @(negedge clk); #1;
      check("stall_fetch_req", fetch_req, 1);
      check("stall_ir_load", ir_load, 0);
      check("stall_state", state, 0);
    end
    @(negedge clk);
    instr = mk(6'h00, 6'h20); instr_valid = 1'b1;
    #1;
    check("add_ir_load", ir_load, 1);
    @(negedge clk);
    instr = mk(6'h3F, 6'h3F);
    #1;
    check("add_s1", state, 1);
    check("add_opcode", alu_opcode, 6'h00);
    check("add_funct", alu_funct, 6'h20);
    check("add_s1_pc_we", pc_we, 0);
    @(negedge clk); #1;
    check("add_s2", state, 2);
    check("add_s2_pc_we", pc_we, 0);
    check("add_s2_funct_hold", alu_funct, 6'h20);
    @(negedge clk); #1;
    check("add_s4", state, 4);
    check("add_reg_we", reg_we, 1);
    check("add_wb_sel", wb_sel, 0);
    check("add_pc_we", pc_we, 1);
    check("add_pc_branch", pc_branch, 0);
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    exp_ret = 16'd1;
    check("add_state_after", state, 0);
    check_flags("add");

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Counter wrap: preload just below the top, then retire two beqs.
    @(negedge clk);
    force dut.retired_q = 16'hFFFE;
    @(negedge clk);
    release dut.retired_q;
    exp_ret = 16'hFFFE;
    run_vec(16, vecs[8]);
    check("wrap_ffff", retired, 16'hFFFF);
    run_vec(17, vecs[9]);
    check("wrap_zero", retired, 16'h0000);

    // Reset asserted while an lw waits in MEM.
    @(negedge clk);
    instr = mk(6'h23, 6'h2A); instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("mrst_in_mem", mem_rd, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_mem_rd", mem_rd, 0);
    check("mrst_pc_we", pc_we, 0);
    check("mrst_reg_we", reg_we, 0);
    check("mrst_fetch_req", fetch_req, 0);
    @(negedge clk); #1;
    exp_ret = 16'd0; exp_ill = 1'b0; exp_tmo = 1'b0;
    check("mrst_state", state, 0);
    check("mrst_opcode", alu_opcode, 0);
    check_flags("mrst");
    rst_n = 1'b1;
    #1;
    check("mrst_resume_fetch", fetch_req, 1);
    run_vec(18, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
